// File: rtl/iir_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// iir_trigger_sequencer
//
// Sequences an IIR trigger filter: latches its configuration at run start,
// flushes its state for four cycles, waits a programmable settle time, then
// qualifies rising edges of the filter's raw trigger into one-cycle pulses
// with a programmable hold-off dead time. Accepted and dropped edges are
// counted with saturating 16-bit counters.
//
// Optional feature (macro IIR_SAT_RECOVERY_EN): when defined, a filter output
// magnitude |filt_y| >= sat_level (sat_level != 0) in ARMED or HOLDOFF sends
// the sequencer to RECOVER, which re-flushes the filter and settles again.
// When undefined, sat_level and filt_y are ignored and RECOVER is unreachable.
//
// Ports
//   clk                  rising-edge clock
//   reset_n              asynchronous active-low reset
//   run                  1 = sequence and run the filter, 0 = return to IDLE
//   threshold_cfg[31:0]  signed threshold, latched at run start
//   output_sel_cfg       filter output select, latched at run start
//   settle_cfg[15:0]     settle cycles after each flush (0 = skip SETTLE)
//   holdoff_cfg[15:0]    dead-time cycles after each trigger (0 = skip HOLDOFF)
//   sat_level[15:0]      unsigned saturation magnitude (0 = detection off)
//   filt_y[15:0]         signed filter output sample
//   trigger_in           raw trigger level from the filter
//   filt_enable          filter enable (every state but IDLE)
//   filt_n1_reset        filter state flush (FLUSH and RECOVER)
//   filt_output_selector latched output select
//   filt_threshold[31:0] latched threshold
//   trig_out             one-cycle qualified trigger pulse
//   trig_count[15:0]     accepted triggers, saturating
//   drop_count[15:0]     edges ignored in SETTLE/HOLDOFF, saturating
//   state[2:0]           encoded FSM state
// -----------------------------------------------------------------------------
module iir_trigger_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] threshold_cfg,
  input  logic        output_sel_cfg,
  input  logic [15:0] settle_cfg,
  input  logic [15:0] holdoff_cfg,
  input  logic [15:0] sat_level,
  input  logic [15:0] filt_y,
  input  logic        trigger_in,
  output logic        filt_enable,
  output logic        filt_n1_reset,
  output logic        filt_output_selector,
  output logic [31:0] filt_threshold,
  output logic        trig_out,
  output logic [15:0] trig_count,
  output logic [15:0] drop_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ARMED   = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam logic [15:0] FLUSH_LAST = 16'd3;  // flush lasts 4 cycles

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        trig_reg_q, trig_reg_d;
  logic        trig_out_q, trig_out_d;
  logic [15:0] trig_count_q, trig_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [31:0] threshold_q, threshold_d;
  logic        out_sel_q, out_sel_d;

  logic        edge_det;
  logic        sat_event;
  logic        settle_done;
  logic        holdoff_done;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign edge_det = trigger_in & ~trig_reg_q;

`ifdef IIR_SAT_RECOVERY_EN
  // Magnitude in 17 bits so that -32768 maps to +32768 rather than wrapping.
  logic [16:0] y_ext;
  logic [16:0] y_abs;
  assign y_ext     = {filt_y[15], filt_y};
  assign y_abs     = y_ext[16] ? (~y_ext + 17'd1) : y_ext;
  assign sat_event = (sat_level != 16'd0) && (y_abs >= {1'b0, sat_level});
`else
  logic sat_inputs_unused;
  assign sat_inputs_unused = ^{sat_level, filt_y};
  assign sat_event         = 1'b0;
`endif

  // Compared in 17 bits; a config lowered mid-wait still terminates at once.
  assign settle_done  = ({1'b0, cnt_q} + 17'd1) >= {1'b0, settle_cfg};
  assign holdoff_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, holdoff_cfg};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trig_out_d   = 1'b0;
    trig_count_d = trig_count_q;
    drop_count_d = drop_count_q;
    threshold_d  = threshold_q;
    out_sel_d    = out_sel_q;
    // The edge register tracks the input outside IDLE, so a level held
    // across a state change never looks like a fresh edge.
    trig_reg_d   = (state_q != ST_IDLE) ? trigger_in : trig_reg_q;

    if (!run) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          threshold_d  = threshold_cfg;
          out_sel_d    = output_sel_cfg;
          trig_count_d = 16'd0;
          drop_count_d = 16'd0;
          cnt_d        = 16'd0;
          state_d      = ST_FLUSH;
        end
        ST_FLUSH, ST_RECOVER: begin
          if (cnt_q == FLUSH_LAST) begin
            cnt_d   = 16'd0;
            state_d = (settle_cfg == 16'd0) ? ST_ARMED : ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (edge_det) drop_count_d = sat_inc(drop_count_q);
          if (settle_done) begin
            cnt_d   = 16'd0;
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_ARMED: begin
          if (sat_event) begin
            cnt_d   = 16'd0;
            state_d = ST_RECOVER;
          end else if (edge_det) begin
            trig_out_d   = 1'b1;
            trig_count_d = sat_inc(trig_count_q);
            cnt_d        = 16'd0;
            state_d      = (holdoff_cfg == 16'd0) ? ST_ARMED : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (sat_event) begin
            cnt_d   = 16'd0;
            state_d = ST_RECOVER;
          end else begin
            if (edge_det) drop_count_d = sat_inc(drop_count_q);
            if (holdoff_done) begin
              cnt_d   = 16'd0;
              state_d = ST_ARMED;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      trig_reg_q   <= 1'b0;
      trig_out_q   <= 1'b0;
      trig_count_q <= 16'd0;
      drop_count_q <= 16'd0;
      threshold_q  <= 32'd0;
      out_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trig_reg_q   <= trig_reg_d;
      trig_out_q   <= trig_out_d;
      trig_count_q <= trig_count_d;
      drop_count_q <= drop_count_d;
      threshold_q  <= threshold_d;
      out_sel_q    <= out_sel_d;
    end
  end

  // Enables decode straight from the state flop so reset clears them at once.
  assign filt_enable          = (state_q != ST_IDLE);
  assign filt_n1_reset        = (state_q == ST_FLUSH) || (state_q == ST_RECOVER);
  assign filt_output_selector = out_sel_q;
  assign filt_threshold       = threshold_q;
  assign trig_out             = trig_out_q;
  assign trig_count           = trig_count_q;
  assign drop_count           = drop_count_q;
  assign state                = state_q;

endmodule

// File: doc/iir_trigger_sequencer.md
IIR_TRIGGER_SEQUENCER -- requirements
Module: iir_trigger_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL have the following ports, each listed as name, direction, width, meaning:
- run, input, 1: software enable; 1 = sequence and run the filter.
- threshold_cfg, input, 32: signed trigger threshold to load into the filter.
- output_sel_cfg, input, 1: filter output-select value to load.
- settle_cfg, input, 16: settle cycles after each flush.
- holdoff_cfg, input, 16: dead-time cycles after each accepted trigger.
- sat_level, input, 16: unsigned saturation magnitude.
- filt_y, input, 16: signed filter output sample.
- trigger_in, input, 1: raw trigger level from the filter.
- filt_enable, output, 1: filter enable.
- filt_n1_reset, output, 1: filter state flush.
- filt_output_selector, output, 1: latched output select.
- filt_threshold, output, 32: latched threshold.
- trig_out, output, 1: one-cycle qualified trigger pulse.
- trig_count, output, 16: accepted-trigger counter.
- drop_count, output, 16: trigger edges ignored during HOLDOFF or SETTLE.
- state, output, 3: encoded FSM state.

Function
REQ-003 The FSM SHALL have these states and encodings: IDLE=0, FLUSH=1, SETTLE=2, ARMED=3, HOLDOFF=4, RECOVER=5.
REQ-004 In IDLE, with run=1, the FSM SHALL latch threshold_cfg into filt_threshold and output_sel_cfg into filt_output_selector, clear trig_count and drop_count, and go to FLUSH the next cycle.
REQ-005 filt_threshold and filt_output_selector SHALL change only on the IDLE->FLUSH transition.
REQ-006 In FLUSH and RECOVER, filt_n1_reset=1 and filt_enable=1 SHALL hold for exactly 4 cycles, after which the FSM SHALL go to SETTLE.
REQ-007 In SETTLE, filt_enable=1 and the FSM SHALL stay for settle_cfg cycles before going to ARMED; settle_cfg=0 SHALL mean ARMED on the next cycle.
REQ-008 Trigger edge detection SHALL work as follows:
- trigger_in is registered once.
- An edge is current trigger_in=1 while the registered copy is 0.
- The edge register SHALL update in every non-IDLE state.
- A level held across a state change SHALL NOT produce a new edge.
REQ-009 In ARMED, an edge SHALL produce trig_out=1 for exactly one cycle, in the cycle after the edge is detected, then trig_count+1 and a move to HOLDOFF.
REQ-010 In HOLDOFF, the FSM SHALL stay for holdoff_cfg cycles and then return to ARMED; holdoff_cfg=0 SHALL mean ARMED on the next cycle.
REQ-011 Edges seen in HOLDOFF or SETTLE SHALL increment drop_count and SHALL NOT assert trig_out.
REQ-012 trig_count and drop_count SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-013 filt_enable SHALL be 1 in every state except IDLE; filt_n1_reset SHALL be 1 only in FLUSH and RECOVER.
REQ-014 When run=0 in any state, the FSM SHALL enter IDLE on the next cycle, and a pending trig_out SHALL be suppressed.
REQ-015 The counters SHALL hold their values in IDLE until the next run start.
REQ-016 A saturation event SHALL be |filt_y| >= sat_level, with |filt_y| computed in 17 bits so that -32768 gives 32768.
REQ-017 A saturation event in ARMED or HOLDOFF SHALL send the FSM to RECOVER.
REQ-018 A saturation event in the same cycle as an ARMED edge SHALL take priority: no trig_out and no count.
REQ-019 sat_level=0 SHALL disable saturation detection.
REQ-020 Priority SHALL be reset_n, then run=0, then saturation, then trigger edge, then counter expiry.

Reset
REQ-021 While reset_n=0, the block SHALL immediately and asynchronously set:
- state to IDLE;
- filt_enable, filt_n1_reset, trig_out and filt_output_selector to 0;
- filt_threshold, trig_count, drop_count, the edge register and the internal cycle counters to 0.
REQ-022 Reset deassertion while run=1 SHALL go through IDLE and then FLUSH, with fresh latching of threshold_cfg and output_sel_cfg.
REQ-023 Assertion of reset_n during any state SHALL abort the sequence with no trig_out pulse.

Configuration
REQ-024 When macro IIR_SAT_RECOVERY_EN is defined, the saturation compare and the RECOVER state SHALL be compiled in as in REQ-016 to REQ-019.
REQ-025 When IIR_SAT_RECOVERY_EN is undefined, sat_level and filt_y SHALL be ignored, RECOVER SHALL be unreachable, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios (stimulus -> required response):
- Start-up: run 0->1, settle_cfg=10 -> 4 cycles of filt_n1_reset=1, ARMED after 10 SETTLE cycles, filt_threshold equals threshold_cfg.
- Trigger and holdoff: ARMED, trigger_in pulse, holdoff_cfg=20 -> one trig_out and trig_count=1; a second pulse 5 cycles later -> drop_count=1 and no trig_out; after holdoff a third pulse -> trig_count=2.
- Counter saturation and config latch: 70000 accepted triggers -> trig_count=0xFFFF; changing threshold_cfg while running -> filt_threshold unchanged.
- Saturation recovery (macro defined): sat_level=1000, filt_y=-1000 in ARMED -> RECOVER, 4 n1_reset cycles, SETTLE; filt_y=-1000 coincident with a trigger edge -> no trig_out.
- Abort: run=0 mid-HOLDOFF -> IDLE next cycle, filt_enable=0; reset_n pulse mid-FLUSH -> all outputs zero immediately.
- Macro undefined: same stimulus as the saturation-recovery case -> state never 5 and the trigger is accepted.
